mem_responder: RTL and testbench
================================

# mem_responder

Byte-wide memory target for the 8-bit multicycle MIPS core: it answers the `memread`/`memwrite`/address/write-data requests the controller and datapath issue, holding `2**AW` bytes of combined instruction/data storage. Accesses take a programmable number of wait cycles, tracked by a small FSM and down-counter. Completion is signalled with a one-cycle `ready` pulse, and read data is held in a register. The block sits between the datapath's address mux (`iord`) and its instruction/data registers.

## Interface
- `AW`, 8, address width; storage depth is `2**AW` bytes
- `LATENCY`, 2, wait cycles inserted before the array access; legal range 0..15
- `clk`  input  1  single clock; all state changes on the rising edge
- `reset`  input  1  asynchronous, active-low reset
- `memread`  input  1  read request strobe
- `memwrite`  input  1  write request strobe
- `adr`  input  AW  byte address
- `writedata`  input  8  byte to store
- `readdata`  output  8  registered read result
- `ready`  output  1  one-cycle completion pulse for the current access
- `busy`  output  1  high whenever state is not IDLE
- `conflict`  output  1  sticky flag: `memread` and `memwrite` were both sampled high in IDLE

## Operation
- **States and outputs**
  - FSM states: IDLE, WAIT, DONE.
  - A 4-bit down-counter `cnt` runs alongside the FSM.
  - Storage is an array of `2**AW` x 8 bits and is not cleared by reset.
- **IDLE**
  - The strobes are sampled only in this state.
  - If `memwrite | memread` is high at an edge, the block latches `adr`, `writedata` and the op (write wins if both strobes are high), loads `cnt <= LATENCY` and moves to WAIT.
  - If both strobes are high at that edge, `conflict <= 1`.
- **WAIT**
  - At each edge, if `cnt != 0`: `cnt <= cnt - 1`.
  - At the edge where `cnt == 0`, the access is performed:
    - Write: `mem[adr_q] <= wdata_q`.
    - Read: `readdata <= mem[adr_q]`.
  - After the access the FSM moves to DONE.
- **DONE**
  - `ready = 1`, decoded from the state.
  - The next edge returns the FSM to IDLE unconditionally.
- **Strobe handling outside IDLE**
  - Strobes and `adr`/`writedata` changes during WAIT or DONE are ignored.
  - The requester may hold or drop them freely.
  - A strobe still high when the FSM re-enters IDLE starts a new access.
- **readdata retention**
  - `readdata` holds its value until the next read completes.
  - Writes never change it.
- **Addressing:** `adr` is exactly AW bits, so there is no wrap logic; 0 through `2**AW-1` are all valid.
- **Reset**
  - Reset is asynchronous and active-low.
  - Reset values: state = IDLE, `cnt = 0`, `readdata = 8'h00`, `ready = 0`, `busy = 0`, `conflict = 0`.
  - Reset asserted mid-access abandons the access: a pending write never reaches the array, and a pending read leaves `readdata` at its reset value.
- **Clearing conflict:** `conflict` is cleared only by reset.

## Timing
- Take the acceptance edge as E0.
- The array access happens at edge E0+LATENCY+1.
- `ready` is high for exactly the cycle following that edge, and is never high two cycles in a row.
- `readdata` is valid in the `ready` cycle and remains valid after it.
- With LATENCY=0: accept at E0, access at E0+1, `ready` in the cycle after E0+1.
- Back-to-back requests with strobes held high: one access per LATENCY+3 cycles.
- `busy` rises in the cycle after E0 and falls in the cycle after the DONE edge.
- `ready` and `busy` are decoded from state registers only, with no combinational path from any input.

## Test plan
- **Write then read, LATENCY=2:** write 0xA5 to 0x10, drop the strobes on `ready`, then read 0x10.
  - `ready` 3 cycles after each acceptance edge.
  - `readdata` = 0xA5.
  - `conflict` stays 0.
- **Retention and read-ignores-write:**
  - Write 0x3C to 0xFF and 0x11 to 0x00.
  - Read 0xFF, which returns 0x3C.
  - Write 0x77 to 0x01; `readdata` still 0x3C.
  - Read 0x00, which returns 0x11.
- **Strobe noise during WAIT:** toggle `memwrite`, `adr` and `writedata` randomly during WAIT of a read of 0x10.
  - `readdata` = 0xA5.
  - No extra array writes; a read-back of every touched address is unchanged.
- **Simultaneous strobes:** `memread` = `memwrite` = 1, `adr` = 0x20, `writedata` = 0x5A in IDLE.
  - The access is a write.
  - `conflict` = 1 from the cycle after acceptance until reset.
  - A later read of 0x20 returns 0x5A.
- **Reset mid-write:** preload 0x40 with 0x99, start a write of 0x00 to 0x40, and assert `reset` low during WAIT.
  - All outputs are at their reset values immediately (asynchronously).
  - A read of 0x40 after release returns 0x99.
- **LATENCY=0 and max throughput:** hold `memread` high continuously.
  - `ready` pulses every 3 cycles.
  - `busy` is low for exactly 1 cycle between accesses.

Source files
------------

// File: rtl/mem_responder.sv
// Byte-wide instruction/data memory target for the 8-bit multicycle MIPS core.
// Latency: access at edge E0+LATENCY+1 after acceptance, one-cycle ready pulse after it.
// Backpressure: strobes are only sampled in IDLE; requests during WAIT/DONE are ignored.
//
// Ports:
//   clk        single clock, rising-edge
//   reset      asynchronous active-low reset
//   memread    read request strobe
//   memwrite   write request strobe (wins when both are high)
//   adr        byte address, AW bits
//   writedata  byte to store
//   readdata   registered read result, held until the next read completes
//   ready      one-cycle completion pulse (state DONE)
//   busy       high whenever the FSM is not IDLE
//   conflict   sticky: both strobes were seen high in IDLE; cleared only by reset
module mem_responder #(
    parameter int AW      = 8,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memread,
    input  logic          memwrite,
    input  logic [AW-1:0] adr,
    input  logic [7:0]    writedata,
    output logic [7:0]    readdata,
    output logic          ready,
    output logic          busy,
    output logic          conflict
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          op_wr_q, op_wr_d;
    logic [7:0]    readdata_q, readdata_d;
    logic          conflict_q, conflict_d;
    logic          mem_we;

    // Storage is deliberately not reset: contents survive a reset pulse.
    logic [7:0]    mem [0:(1<<AW)-1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        adr_d      = adr_q;
        wdata_d    = wdata_q;
        op_wr_d    = op_wr_q;
        readdata_d = readdata_q;
        conflict_d = conflict_q;
        mem_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (memwrite || memread) begin
                    adr_d   = adr;
                    wdata_d = writedata;
                    op_wr_d = memwrite;
                    cnt_d   = LAT;
                    state_d = ST_WAIT;
                    if (memwrite && memread) begin
                        conflict_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Counter exhausted: perform the latched access this edge.
                    if (op_wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        readdata_d = mem[adr_q];
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            adr_q      <= '0;
            wdata_q    <= 8'h00;
            op_wr_q    <= 1'b0;
            readdata_q <= 8'h00;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            adr_q      <= adr_d;
            wdata_q    <= wdata_d;
            op_wr_q    <= op_wr_d;
            readdata_q <= readdata_d;
            conflict_q <= conflict_d;
        end
    end

    // mem_we can only be high in WAIT, so a reset held low (state forced to
    // IDLE) guarantees an abandoned write never lands in the array.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[adr_q] <= wdata_q;
        end
    end

    // Status outputs decode state registers only; no input-to-output path.
    assign ready    = (state_q == ST_DONE);
    assign busy     = (state_q != ST_IDLE);
    assign readdata = readdata_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       reset;
    // LATENCY=2 instance
    logic       mr, mw;
    logic [7:0] adr, wd;
    logic [7:0] rd;
    logic       rdy, bsy, cfl;
    // LATENCY=0 instance
    logic       mr0, mw0;
    logic [7:0] adr0, wd0;
    logic [7:0] rd0;
    logic       rdy0, bsy0, cfl0;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int lat;

    always #5 clk = ~clk;

    mem_responder #(.AW(8), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .memread(mr), .memwrite(mw), .adr(adr),
        .writedata(wd), .readdata(rd), .ready(rdy), .busy(bsy), .conflict(cfl)
    );

    mem_responder #(.AW(8), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .memread(mr0), .memwrite(mw0), .adr(adr0),
        .writedata(wd0), .readdata(rd0), .ready(rdy0), .busy(bsy0), .conflict(cfl0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives a request at a falling edge, then counts falling edges until
    // ready is seen (lat = -1 on timeout) and drops the strobes there.
    // With LATENCY=2 the ready cycle is the 4th falling edge after driving:
    // accept E0, count 2->1 at E0+1, 1->0 at E0+2, access at E0+3.
    task automatic access(input logic do_rd, input logic do_wr,
                          input logic [7:0] a, input logic [7:0] d,
                          output int l);
        @(negedge clk);
        mr = do_rd; mw = do_wr; adr = a; wd = d;
        l = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rdy) begin
                l = k;
                break;
            end
        end
        mr = 1'b0; mw = 1'b0;
    endtask

    initial begin
        logic [7:0] noise_adr;
        reset = 1'b0;
        mr = 0; mw = 0; adr = 0; wd = 0;
        mr0 = 0; mw0 = 0; adr0 = 0; wd0 = 0;
        #1;
        check("rst_readdata", rd, 8'h00);
        check("rst_ready", rdy, 1'b0);
        check("rst_busy", bsy, 1'b0);
        check("rst_conflict", cfl, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Write then read
        access(1'b0, 1'b1, 8'h10, 8'hA5, lat);
        check("wr10_lat", lat, 4);
        access(1'b1, 1'b0, 8'h10, 8'h00, lat);
        check("rd10_lat", lat, 4);
        check("rd10_data", rd, 8'hA5);
        check("rd10_conflict", cfl, 1'b0);

        // Retention; writes never disturb readdata
        access(1'b0, 1'b1, 8'hFF, 8'h3C, lat);
        access(1'b0, 1'b1, 8'h00, 8'h11, lat);
        access(1'b1, 1'b0, 8'hFF, 8'h00, lat);
        check("rdFF_data", rd, 8'h3C);
        access(1'b0, 1'b1, 8'h01, 8'h77, lat);
        check("wr01_lat", lat, 4);
        check("retain_after_wr", rd, 8'h3C);
        access(1'b1, 1'b0, 8'h00, 8'h00, lat);
        check("rd00_data", rd, 8'h11);

        // Noise on strobes/address/data during WAIT of a read of 0x10;
        // noise addresses stay inside the set with known contents.
        @(negedge clk);
        mr = 1'b1; mw = 1'b0; adr = 8'h10; wd = 8'h00;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rdy) begin
                lat = k;
                break;
            end
            case ($urandom_range(0, 3))
                0: noise_adr = 8'h10;
                1: noise_adr = 8'hFF;
                2: noise_adr = 8'h00;
                default: noise_adr = 8'h01;
            endcase
            mw  = 1'($urandom_range(0, 1));
            mr  = 1'($urandom_range(0, 1));
            adr = noise_adr;
            wd  = 8'($urandom);
        end
        mr = 1'b0; mw = 1'b0;
        check("noise_lat", lat, 4);
        check("noise_rd10", rd, 8'hA5);
        access(1'b1, 1'b0, 8'hFF, 8'h00, lat);
        check("noise_keepFF", rd, 8'h3C);
        access(1'b1, 1'b0, 8'h00, 8'h00, lat);
        check("noise_keep00", rd, 8'h11);
        access(1'b1, 1'b0, 8'h01, 8'h00, lat);
        check("noise_keep01", rd, 8'h77);
        access(1'b1, 1'b0, 8'h10, 8'h00, lat);
        check("noise_keep10", rd, 8'hA5);

        // Both strobes: write wins, conflict sticks
        @(negedge clk);
        mr = 1'b1; mw = 1'b1; adr = 8'h20; wd = 8'h5A;
        @(negedge clk);
        mr = 1'b0; mw = 1'b0;
        check("conflict_set", cfl, 1'b1);
        check("conflict_busy", bsy, 1'b1);
        repeat (4) @(negedge clk);
        check("conflict_wr_keeps_rd", rd, 8'hA5);
        access(1'b1, 1'b0, 8'h20, 8'h00, lat);
        check("conflict_rd20", rd, 8'h5A);
        check("conflict_sticky", cfl, 1'b1);

        // Reset during WAIT of a write abandons it
        access(1'b0, 1'b1, 8'h40, 8'h99, lat);
        check("pre40_lat", lat, 4);
        @(negedge clk);
        mw = 1'b1; adr = 8'h40; wd = 8'h00;
        @(negedge clk);
        check("midwr_busy", bsy, 1'b1);
        #1;
        reset = 1'b0;
        mw = 1'b0;
        #1;
        check("arst_busy", bsy, 1'b0);
        check("arst_ready", rdy, 1'b0);
        check("arst_readdata", rd, 8'h00);
        check("arst_conflict", cfl, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        access(1'b1, 1'b0, 8'h40, 8'h00, lat);
        check("rd40_after_rst", rd, 8'h99);
        check("rd40_conflict", cfl, 1'b0);

        // LATENCY=0 with memread held: period of 3, one idle cycle between.
        @(negedge clk);
        mr0 = 1'b1; adr0 = 8'h05;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("l0_ready_%0d", k), rdy0, ((k % 3) == 2) ? 1'b1 : 1'b0);
            check($sformatf("l0_busy_%0d", k), bsy0, ((k % 3) != 0) ? 1'b1 : 1'b0);
        end
        mr0 = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
